// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for the jk_excite_drv block.
// Codes are packed {j, k}.
package jk_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StCheck = 2'b10
  } state_e;

  localparam logic [1:0] JkHold = 2'b00;
  localparam logic [1:0] JkRst  = 2'b01;
  localparam logic [1:0] JkSet  = 2'b10;
  localparam logic [1:0] JkTgl  = 2'b11;

endpackage

// File: rtl/jk_excite_drv_if.sv
// Target stream and JK bank connection for jk_excite_drv.
// The master side is the target source plus the JK bank; the slave side is the driver.
interface jk_excite_drv_if #(
  parameter int unsigned WIDTH = 4
);

  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             jk_valid;
  logic [WIDTH-1:0] q_fb;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, jk_valid
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, jk_valid
  );

endinterface

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation (current q, wanted next q -> j, k).
// JK_TOGGLE_EN selects toggle codes for changing bits; otherwise set/reset codes.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q_i,
  input  logic qn_i,
  output logic j_o,
  output logic k_o
);

`ifdef JK_TOGGLE_EN
  localparam logic [1:0] JkRise = JkTgl;
  localparam logic [1:0] JkFall = JkTgl;
`else
  localparam logic [1:0] JkRise = JkSet;
  localparam logic [1:0] JkFall = JkRst;
`endif

  logic [1:0] code;

  // Don't-care halves of the excitation table are tied to 0.
  always_comb begin
    code = JkHold;
    case ({q_i, qn_i})
      2'b01:   code = JkRise;
      2'b10:   code = JkFall;
      default: code = JkHold;
    endcase
  end

  assign j_o = code[1];
  assign k_o = code[0];

endmodule

// File: rtl/jk_excite_drv.sv
// Drives a JK flip-flop bank through a stream of target states and checks its feedback.
// Build with JK_TOGGLE_EN defined to use toggle excitation for changing bits.
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  jk_excite_drv_if.slave     bus,
  input  logic               err_clr,
  output logic               err_sticky,
  output logic [ERR_W-1:0]   err_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] q_mir_q, q_mir_d;
  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit u_bit (
      .q_i  (q_mir_q[i]),
      .qn_i (bus.tgt_data[i]),
      .j_o  (exc_j[i]),
      .k_o  (exc_k[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    j_d      = '0;
    k_d      = '0;
    q_mir_d  = q_mir_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = StDrive;
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StCheck: begin
        // Mirror follows the real bank so a stuck bit does not poison later targets.
        q_mir_d = bus.q_fb;
        state_d = StIdle;
        if (bus.q_fb != tgt_q) begin
          sticky_d = 1'b1;
          if (cnt_d != '1) begin
            cnt_d = cnt_d + ERR_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      q_mir_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      q_mir_q  <= q_mir_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.jk_valid  = (state_q == StDrive);
  assign bus.tgt_ready = (state_q == StIdle);
  assign err_sticky    = sticky_q;
  assign err_cnt       = cnt_q;

endmodule
